ctx_cost_rmw_sched: RTL

Round-robin read-modify-write scheduler that shares one context bit-cost register file (24 contexts × 2 bins × 16-bit costs, combinational read, synchronous write) between several cost-update engines in the CABAC rate estimator. Each requester submits a context, a bin and a signed cost delta. The block arbitrates, reads the current cost, adds the delta, writes the result back and returns the new cost. Only one RMW is in flight at a time, so updates to the same context are never lost.

---
 rtl/ctx_cost_rmw_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ctx_cost_rmw_sched.sv
// Round-robin read-modify-write scheduler sharing one context bit-cost register file among cost-update engines.
// Optional CTX_RMW_SAT_EN: clamp the updated cost to [0, 2^DATA_W-1] instead of wrapping.
module ctx_cost_rmw_sched #(
  parameter int NUM_REQ = 4,
  parameter int NUM_CTX = 24,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [5*NUM_REQ-1:0]      req_ctx,
  input  logic [NUM_REQ-1:0]        req_bin,
  input  logic [DATA_W*NUM_REQ-1:0] req_delta,
  output logic                      rsp_valid,
  output logic [2:0]                rsp_id,
  output logic [DATA_W-1:0]         rsp_cost,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      rf_we,
  output logic [7:0]                rf_ctx_addr,
  output logic                      rf_bin_val,
  output logic [DATA_W-1:0]         rf_bit_cost_in,
  output logic [4:0]                rf_read_ctx_addr,
  output logic                      rf_read_bin_sel,
  input  logic [DATA_W-1:0]         rf_bit_cost_out
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t                    state;
  logic [2:0]                rr_ptr;
  logic [7:0]                valid_ext;
  logic [4:0]                ctx_arr   [8];
  logic                      bin_arr   [8];
  logic signed [DATA_W-1:0]  delta_arr [8];
  logic                      gnt_found;
  logic [2:0]                gnt_idx;
  logic [3:0]                scan;
  logic signed [DATA_W-1:0]  delta_p0;
  logic [2:0]                id_p0;
  logic signed [DATA_W+1:0]  sum_p1;
  logic                      in_range_p1;

  function automatic logic [DATA_W-1:0] reduce_cost(input logic signed [DATA_W+1:0] s);
`ifdef CTX_RMW_SAT_EN
    if (s < 0)
      return '0;
    else if (s > $signed({2'b00, {DATA_W{1'b1}}}))
      return '1;
    else
      return DATA_W'(s);
`else
    return DATA_W'(s);
`endif
  endfunction

  // Unpack the flat request buses into fixed 8-entry views so a 3-bit grant index selects exactly.
  always_comb begin
    valid_ext = '0;
    for (int i = 0; i < 8; i++) begin
      ctx_arr[i]   = '0;
      bin_arr[i]   = 1'b0;
      delta_arr[i] = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      valid_ext[i] = req_valid[i];
      ctx_arr[i]   = req_ctx[5*i +: 5];
      bin_arr[i]   = req_bin[i];
      delta_arr[i] = req_delta[DATA_W*i +: DATA_W];
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + 4'(k);
      if (scan >= 4'(NUM_REQ))
        scan = scan - 4'(NUM_REQ);
      if (!gnt_found && valid_ext[scan[2:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[2:0];
      end
    end
  end

  assign req_ready = (state == IDLE && gnt_found) ? (NUM_REQ'(1'b1) << gnt_idx) : '0;
  assign busy      = (state != IDLE);

  // p0: payload latched at accept
  always_ff @(posedge clk) begin
    if (state == IDLE && gnt_found) begin
      delta_p0 <= delta_arr[gnt_idx];
      id_p0    <= gnt_idx;
    end
  end

  // p1: combinational read data joins the delta in the RD cycle
  assign sum_p1      = $signed({2'b00, rf_bit_cost_out}) + $signed({{2{delta_p0[DATA_W-1]}}, delta_p0});
  assign in_range_p1 = ({1'b0, rf_read_ctx_addr} < 6'(NUM_CTX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      rsp_valid        <= 1'b0;
      rsp_id           <= '0;
      rsp_cost         <= '0;
      rsp_err          <= 1'b0;
      rf_we            <= 1'b0;
      rf_ctx_addr      <= '0;
      rf_bin_val       <= 1'b0;
      rf_bit_cost_in   <= '0;
      rf_read_ctx_addr <= '0;
      rf_read_bin_sel  <= 1'b0;
    end else begin
      rf_we     <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            rf_read_ctx_addr <= ctx_arr[gnt_idx];
            rf_read_bin_sel  <= bin_arr[gnt_idx];
            state            <= RD;
          end
        end
        RD: begin
          rsp_valid      <= 1'b1;
          rsp_id         <= id_p0;
          rf_ctx_addr    <= {3'b000, rf_read_ctx_addr};
          rf_bin_val     <= rf_read_bin_sel;
          rf_bit_cost_in <= reduce_cost(sum_p1);
          if (in_range_p1) begin
            rf_we    <= 1'b1;
            rsp_err  <= 1'b0;
            rsp_cost <= reduce_cost(sum_p1);
          end else begin
            rsp_err  <= 1'b1;
            rsp_cost <= '0;
          end
          state <= WR;
        end
        WR: begin
          rr_ptr <= (id_p0 == 3'(NUM_REQ-1)) ? 3'd0 : id_p0 + 3'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
